fetch_stage: RTL and testbench

- Instruction-fetch stage: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes the load-use stall pair from the hazard detection unit (pc_keep_i, IF_ID_keep_i) and the branch redirect from ID.
- Produces the IF/ID instruction whose rs/rt fields feed hazard detection and decode.
- Tolerates variable-latency instruction memory via a req/ack handshake and a one-entry hold buffer.

---
 rtl/fetch_stage_pkg.sv | 36 +++
 rtl/fetch_stage_pc_reg.sv | 57 +++++
 rtl/fetch_stage.sv | 209 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// PC next-value selects, the NOP encoding and the register-field width that
// decode uses to slice rs/rt out of IF_ID_instr_o.

`ifndef R_WIDTH
`define R_WIDTH 5
`endif

package fetch_stage_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

    // Next-value select for the PC register
    typedef enum logic [1:0] {
        PC_SEL_INC    = 2'd0,
        PC_SEL_TARGET = 2'd1,
        PC_SEL_REDIR  = 2'd2
    } pc_sel_e;

    // All-zero word is treated as the pipeline bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Width of a register-specifier field in the instruction word
    localparam int unsigned REG_FIELD_WIDTH = `R_WIDTH;

    // Word-align an address by clearing its two low bits
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program-counter register for the fetch stage. Holds the PC with an
// asynchronous reset to RESET_PC and selects the next value from pc+4, the
// branch target or the saved redirect address. The keep input only blocks
// the sequential pc+4 advance; redirects still load.

module fetch_stage_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_en_i,
    input  logic                  keep_i,
    input  pc_sel_e               sel_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    input  logic [ADDR_WIDTH-1:0] redir_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  advance_blocked;

    // pc+4 wraps naturally modulo 2^ADDR_WIDTH
    assign pc_plus4        = pc_q + ADDR_WIDTH'(4);
    assign advance_blocked = keep_i && (sel_i == PC_SEL_INC);

    // Choose the next PC; hold unless a non-blocked load is requested
    always_comb begin
        pc_d = pc_q;
        if (load_en_i && !advance_blocked) begin
            case (sel_i)
                PC_SEL_INC:    pc_d = pc_plus4;
                PC_SEL_TARGET: pc_d = target_i;
                PC_SEL_REDIR:  pc_d = redir_i;
                default:       pc_d = pc_q;
            endcase
        end
    end

    // PC state register with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory req/ack handshake with a
// one-entry hold buffer, and the IF/ID pipeline register. Honours the
// load-use stall pair from hazard detection and branch redirects from ID.
// Optional macro FETCH_STALL_CNT_EN adds a saturating 32-bit counter of
// cycles spent waiting on memory (req=1, ack=0).

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pc_keep_i,
    input  logic                  IF_ID_keep_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [ADDR_WIDTH-1:0] IF_ID_pc_o,
    output logic [ADDR_WIDTH-1:0] IF_ID_pc_plus4_o,
    output logic [DATA_WIDTH-1:0] IF_ID_instr_o,
    output logic                  IF_ID_valid_o
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]           fetch_stall_cnt_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

    fetch_state_e          state_q, state_d;

    logic [ADDR_WIDTH-1:0] if_id_pc_q, if_id_pc_d;
    logic [ADDR_WIDTH-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic [DATA_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
    logic                  if_id_valid_q, if_id_valid_d;

    logic [ADDR_WIDTH-1:0] buf_pc_q, buf_pc_d;
    logic [DATA_WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic [ADDR_WIDTH-1:0] redir_q, redir_d;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] target_aligned;
    logic                  pc_load;
    pc_sel_e               pc_sel;
    logic                  ack_seen;
    logic                  unused_target_bits;

    // Low target bits are dropped so every fetch stays word-aligned
    assign target_aligned     = {branch_target_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_target_bits = ^branch_target_i[1:0];

    // Request is live in every state except HOLD, and never during reset
    assign imem_req_o  = !rst_i && (state_q != S_HOLD);
    assign imem_addr_o = pc;
    assign ack_seen    = imem_ack_i && imem_req_o;

    fetch_stage_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_en_i  (pc_load),
        .keep_i     (pc_keep_i),
        .sel_i      (pc_sel),
        .target_i   (target_aligned),
        .redir_i    (redir_q),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4)
    );

    // Fetch controller: next state, IF/ID update, hold buffer and PC control
    always_comb begin
        state_d          = state_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_valid_d    = if_id_valid_q;
        buf_pc_d         = buf_pc_q;
        buf_instr_d      = buf_instr_q;
        redir_d          = redir_q;
        pc_load          = 1'b0;
        pc_sel           = PC_SEL_INC;

        case (state_q)
            S_FETCH: begin
                if (branch_taken_i) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP;
                    if (ack_seen) begin
                        pc_load = 1'b1;
                        pc_sel  = PC_SEL_TARGET;
                    end else begin
                        redir_d = target_aligned;
                        state_d = S_DISCARD;
                    end
                end else if (ack_seen && !IF_ID_keep_i) begin
                    if_id_pc_d       = pc;
                    if_id_pc_plus4_d = pc_plus4;
                    if_id_instr_d    = imem_rdata_i;
                    if_id_valid_d    = 1'b1;
                    pc_load          = 1'b1;
                    pc_sel           = PC_SEL_INC;
                end else if (ack_seen) begin
                    buf_pc_d    = pc;
                    buf_instr_d = imem_rdata_i;
                    state_d     = S_HOLD;
                end else if (!IF_ID_keep_i) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP;
                end
            end

            S_HOLD: begin
                if (branch_taken_i) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP;
                    pc_load       = 1'b1;
                    pc_sel        = PC_SEL_TARGET;
                    state_d       = S_FETCH;
                end else if (!IF_ID_keep_i) begin
                    if_id_pc_d       = buf_pc_q;
                    if_id_pc_plus4_d = buf_pc_q + ADDR_WIDTH'(4);
                    if_id_instr_d    = buf_instr_q;
                    if_id_valid_d    = 1'b1;
                    pc_load          = 1'b1;
                    pc_sel           = PC_SEL_INC;
                    state_d          = S_FETCH;
                end
            end

            S_DISCARD: begin
                if (branch_taken_i) begin
                    redir_d = target_aligned;
                end
                if (ack_seen) begin
                    pc_load = 1'b1;
                    pc_sel  = branch_taken_i ? PC_SEL_TARGET : PC_SEL_REDIR;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Controller state, IF/ID register, hold buffer and redirect latch
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= S_FETCH;
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= '0;
            if_id_instr_q    <= NOP;
            if_id_valid_q    <= 1'b0;
            buf_pc_q         <= '0;
            buf_instr_q      <= NOP;
            redir_q          <= '0;
        end else begin
            state_q          <= state_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_valid_q    <= if_id_valid_d;
            buf_pc_q         <= buf_pc_d;
            buf_instr_q      <= buf_instr_d;
            redir_q          <= redir_d;
        end
    end

    assign IF_ID_pc_o       = if_id_pc_q;
    assign IF_ID_pc_plus4_o = if_id_pc_plus4_q;
    assign IF_ID_instr_o    = if_id_instr_q;
    assign IF_ID_valid_o    = if_id_valid_q;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count memory-wait cycles, saturating at all ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (imem_req_o && !imem_ack_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_stall_cnt_o = stall_cnt_q;
`else
    // Without the counter option no stall statistics are kept
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. Memory returns
// {16'hC0DE, addr[15:0]} for every address; ack timing is scripted.

module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        pcKeep;
    logic        ifIdKeep;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic [31:0] ifIdPc;
    logic [31:0] ifIdPcPlus4;
    logic [31:0] ifIdInstr;
    logic        ifIdValid;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stallCnt;
`endif

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .pc_keep_i        (pcKeep),
        .IF_ID_keep_i     (ifIdKeep),
        .branch_taken_i   (branchTaken),
        .branch_target_i  (branchTarget),
        .imem_req_o       (imemReq),
        .imem_addr_o      (imemAddr),
        .imem_ack_i       (imemAck),
        .imem_rdata_i     (imemRdata),
        .IF_ID_pc_o       (ifIdPc),
        .IF_ID_pc_plus4_o (ifIdPcPlus4),
        .IF_ID_instr_o    (ifIdInstr),
        .IF_ID_valid_o    (ifIdValid)
`ifdef FETCH_STALL_CNT_EN
        ,
        .fetch_stall_cnt_o (stallCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory data is a fixed tag plus the low address half
    always_comb imemRdata = {16'hC0DE, imemAddr[15:0]};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic keep, input logic pKeep, input logic br,
                                 input logic [31:0] tgt, input logic ack);
        ifIdKeep     = keep;
        pcKeep       = pKeep;
        branchTaken  = br;
        branchTarget = tgt;
        imemAck      = ack;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req", imemReq, 32'h0);
        checkOutput("rst_valid", ifIdValid, 32'h0);
        checkOutput("rst_pc", ifIdPc, 32'h0);
        checkOutput("rst_plus4", ifIdPcPlus4, 32'h0);
        checkOutput("rst_instr", ifIdInstr, 32'h0);
        checkOutput("rst_addr", imemAddr, 32'h0);
`ifdef FETCH_STALL_CNT_EN
        checkOutput("rst_cnt", stallCnt, 32'h0);
`endif
        rst = 1'b0;
        #1;
        checkOutput("first_req", imemReq, 32'h1);

        // Zero-latency memory, no stalls
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("seq_addr", imemAddr, 32'(i * 4));
            stepCycle();
            checkOutput("seq_pc", ifIdPc, 32'(i * 4));
            checkOutput("seq_plus4", ifIdPcPlus4, 32'(i * 4 + 4));
            checkOutput("seq_instr", ifIdInstr, {16'hC0DE, 16'(i * 4)});
            checkOutput("seq_valid", ifIdValid, 32'h1);
        end

        // Two-cycle memory latency on 0x10
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            stepCycle();
            checkOutput("wait_valid", ifIdValid, 32'h0);
            checkOutput("wait_instr", ifIdInstr, 32'h0);
            checkOutput("wait_addr", imemAddr, 32'h10);
            checkOutput("wait_req", imemReq, 32'h1);
        end
`ifdef FETCH_STALL_CNT_EN
        checkOutput("stall_cnt", stallCnt, 32'd2);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        stepCycle();
        checkOutput("late_pc", ifIdPc, 32'h10);
        checkOutput("late_valid", ifIdValid, 32'h1);

        // Load-use stall while 0x14 returns
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("keep_addr", imemAddr, 32'h14);
        stepCycle();
        checkOutput("hold_pc", ifIdPc, 32'h10);
        checkOutput("hold_instr", ifIdInstr, 32'hC0DE_0010);
        checkOutput("hold_req", imemReq, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        stepCycle();
        checkOutput("unhold_pc", ifIdPc, 32'h14);
        checkOutput("unhold_instr", ifIdInstr, 32'hC0DE_0014);
        checkOutput("unhold_valid", ifIdValid, 32'h1);
        checkOutput("unhold_req", imemReq, 32'h1);
        checkOutput("unhold_addr", imemAddr, 32'h18);

        // Fetch 0x18, 0x1C, then branch while 0x20 is outstanding
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("pre_br_pc", ifIdPc, 32'h1C);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        stepCycle();
        checkOutput("br_valid", ifIdValid, 32'h0);
        checkOutput("br_instr", ifIdInstr, 32'h0);
        checkOutput("disc_addr", imemAddr, 32'h20);
        checkOutput("disc_req", imemReq, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("disc_addr2", imemAddr, 32'h20);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        stepCycle();
        checkOutput("redir_addr", imemAddr, 32'h100);
        checkOutput("redir_valid", ifIdValid, 32'h0);
        stepCycle();
        checkOutput("tgt_pc", ifIdPc, 32'h100);
        checkOutput("tgt_instr", ifIdInstr, 32'hC0DE_0100);
        checkOutput("tgt_valid", ifIdValid, 32'h1);

        // Branch and stall together: flush wins, target aligned
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h203, 1'b1);
        stepCycle();
        checkOutput("flush_valid", ifIdValid, 32'h0);
        checkOutput("flush_addr", imemAddr, 32'h200);
        checkOutput("flush_req", imemReq, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        stepCycle();
        checkOutput("flush_pc", ifIdPc, 32'h200);

        // Wrap-around at the top of the address space
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        stepCycle();
        checkOutput("top_addr", imemAddr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        stepCycle();
        checkOutput("wrap_pc", ifIdPc, 32'hFFFF_FFFC);
        checkOutput("wrap_plus4", ifIdPcPlus4, 32'h0);
        checkOutput("wrap_addr", imemAddr, 32'h0);

        // Reset while a request is outstanding
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        stepCycle();
        rst = 1'b1;
        #1;
        checkOutput("midrst_req", imemReq, 32'h0);
        checkOutput("midrst_valid", ifIdValid, 32'h0);
        checkOutput("midrst_pc", ifIdPc, 32'h0);
        checkOutput("midrst_plus4", ifIdPcPlus4, 32'h0);
        checkOutput("midrst_instr", ifIdInstr, 32'h0);
        stepCycle();
        rst = 1'b0;

        // pc_keep alone blocks only the PC advance
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        stepCycle();
        checkOutput("pkeep_valid", ifIdValid, 32'h1);
        checkOutput("pkeep_addr", imemAddr, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        stepCycle();
        checkOutput("pkeep_pc", ifIdPc, 32'h0);
        checkOutput("pkeep_next", imemAddr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
